// File: rtl/dithering_error_engine.sv
// Floyd-Steinberg per-pixel datapath: quantise one pixel, then diffuse its error into
// E/SW/S/SE over a single SRAM port. Optional macro ERR_ROUND_EN selects round-half-up diffusion.
module dithering_error_engine #(
    parameter int IMAGEX           = 64,
    parameter int IMAGEY           = 64,
    parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGEX*IMAGEY),
    parameter int RGB_SIZE         = 8,
    parameter int THRESHOLD        = 128
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [IMAGE_ADDR_WIDTH-1:0] px_idx,
    output logic                        busy,
    output logic                        done,
    output logic [IMAGE_ADDR_WIDTH-1:0] sram_addr,
    output logic                        sram_rden,
    output logic                        sram_wren,
    output logic [RGB_SIZE-1:0]         sram_wdata,
    input  logic [RGB_SIZE-1:0]         sram_rdata,
    output logic signed [8:0]           err_q
);
    localparam int XW = $clog2(IMAGEX);
    localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_ROW = IMAGE_ADDR_WIDTH'(IMAGEX*(IMAGEY-1));

    typedef enum logic [2:0] {
        IDLE, RD_OLD, WAIT_OLD, WR_NEW, RD_N, WAIT_N, WR_N, DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [IMAGE_ADDR_WIDTH-1:0] idx_q, idx_d, addr_q, addr_d;
    logic [2:0]                  nb_q, nb_d, nxt_s;
    logic signed [8:0]           err_d;
    logic                        rden_q, rden_d, wren_q, wren_d, done_q, done_d, busy_q, busy_d;
    logic [7:0]                  wdata_q, wdata_d, new_s;
    logic [XW-1:0]               x_s;
    logic                        x_last_s, x_first_s, last_row_s;
    logic [3:0]                  nb_en_s;
    logic signed [12:0]          prod_s, delta_s;
    logic signed [9:0]           nb_sum_s;

    // Neighbour index 0..3 = E, SW, S, SE.
    function automatic logic signed [12:0] weight(input logic [2:0] sel);
        case (sel)
            3'd0:    weight = 13'sd7;
            3'd1:    weight = 13'sd3;
            3'd2:    weight = 13'sd5;
            3'd3:    weight = 13'sd1;
            default: weight = 13'sd0;
        endcase
    endfunction

    function automatic logic [IMAGE_ADDR_WIDTH-1:0] nb_addr(input logic [IMAGE_ADDR_WIDTH-1:0] idx,
                                                            input logic [2:0] sel);
        case (sel)
            3'd0:    nb_addr = idx + IMAGE_ADDR_WIDTH'(1);
            3'd1:    nb_addr = idx + IMAGE_ADDR_WIDTH'(IMAGEX-1);
            3'd2:    nb_addr = idx + IMAGE_ADDR_WIDTH'(IMAGEX);
            3'd3:    nb_addr = idx + IMAGE_ADDR_WIDTH'(IMAGEX+1);
            default: nb_addr = idx;
        endcase
    endfunction

    // Lowest enabled neighbour at or above 'from'; 4 means none left.
    function automatic logic [2:0] next_nb(input logic [3:0] en, input logic [2:0] from);
        next_nb = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (en[i] && (3'(i) >= from)) next_nb = 3'(i);
        end
    endfunction

    function automatic logic [7:0] sat8(input logic signed [9:0] s);
        if (s < 10'sd0)        sat8 = 8'd0;
        else if (s > 10'sd255) sat8 = 8'd255;
        else                   sat8 = s[7:0];
    endfunction

    // Edge classification of the latched pixel and error diffusion arithmetic.
    always_comb begin
        x_s        = idx_q[XW-1:0];
        x_last_s   = (x_s == XW'(IMAGEX-1));
        x_first_s  = (x_s == {XW{1'b0}});
        last_row_s = (idx_q >= LAST_ROW);
        nb_en_s    = {!x_last_s && !last_row_s, !last_row_s, !x_first_s && !last_row_s, !x_last_s};
        new_s      = (sram_rdata >= 8'(THRESHOLD)) ? 8'd255 : 8'd0;
        prod_s     = $signed({{4{err_q[8]}}, err_q}) * weight(nb_q);
`ifdef ERR_ROUND_EN
        delta_s    = (prod_s + 13'sd8) >>> 4;
`else
        delta_s    = prod_s >>> 4;
`endif
        nb_sum_s   = $signed({2'b00, sram_rdata}) + $signed(delta_s[9:0]);
        nxt_s      = next_nb(nb_en_s, (state_q == WR_NEW) ? 3'd0 : (nb_q + 3'd1));
    end

    // Next state; outputs are computed for the state being entered and then registered.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        nb_d    = nb_q;
        err_d   = err_q;
        addr_d  = addr_q;
        rden_d  = 1'b0;
        wren_d  = 1'b0;
        wdata_d = 8'd0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RD_OLD;
                    idx_d   = px_idx;
                    addr_d  = px_idx;
                    rden_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_OLD:   state_d = WAIT_OLD;
            WAIT_OLD: begin
                state_d = WR_NEW;
                err_d   = $signed({1'b0, sram_rdata}) - $signed({1'b0, new_s});
                wren_d  = 1'b1;
                wdata_d = new_s;
            end
            WR_NEW, WR_N: begin
                if (nxt_s[2]) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RD_N;
                    nb_d    = nxt_s;
                    addr_d  = nb_addr(idx_q, nxt_s);
                    rden_d  = 1'b1;
                end
            end
            RD_N:     state_d = WAIT_N;
            WAIT_N: begin
                state_d = WR_N;
                wren_d  = 1'b1;
                wdata_d = sat8(nb_sum_s);
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            nb_q    <= 3'd0;
            err_q   <= 9'sd0;
            addr_q  <= '0;
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
            wdata_q <= 8'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nb_q    <= nb_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            rden_q  <= rden_d;
            wren_q  <= wren_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign sram_addr  = addr_q;
    assign sram_rden  = rden_q;
    assign sram_wren  = wren_q;
    assign sram_wdata = wdata_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dithering_error_engine.sv
// Directed self-checking bench for dithering_error_engine with a behavioural 1-cycle-latency SRAM.
module tb_dithering_error_engine;
    logic              clk = 1'b0;
    logic              rst_n, start;
    logic [11:0]       px_idx, sram_addr;
    logic              busy, done, sram_rden, sram_wren;
    logic [7:0]        sram_wdata, sram_rdata;
    logic signed [8:0] err_q;

    logic [7:0]  mem [0:4095];
    logic        touched [0:4095];
    logic        ld_en = 1'b0, clr = 1'b0;
    logic [11:0] ld_addr = 12'd0;
    logic [7:0]  ld_data = 8'd0;
    int          cyc = 0, done_cnt = 0, excl_err = 0;
    int          n_checks = 0, n_fail = 0, lat, ntouch;

    dithering_error_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .px_idx(px_idx),
        .busy(busy), .done(done), .sram_addr(sram_addr), .sram_rden(sram_rden),
        .sram_wren(sram_wren), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .err_q(err_q)
    );

    always #5 clk = ~clk;

    // SRAM model plus preload port; read data appears the cycle after rden.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_en)     mem[ld_addr] <= ld_data;
        if (sram_wren) mem[sram_addr] <= sram_wdata;
        if (sram_rden) sram_rdata <= mem[sram_addr];
    end

    // Bus monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) touched[i] = 1'b0;
            done_cnt = 0;
            excl_err = 0;
        end else begin
            if (sram_rden || sram_wren) touched[sram_addr] = 1'b1;
            if (done) done_cnt = done_cnt + 1;
            if (sram_rden && sram_wren) excl_err = excl_err + 1;
        end
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int rv(input int trunc_v, input int round_v);
`ifdef ERR_ROUND_EN
        return round_v;
`else
        return trunc_v;
`endif
    endfunction

    task automatic poke(input int a, input int d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 12'(a); ld_data = 8'(d);
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic clear_mon();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    // Start one pixel; lat = k where DONE lies in cycle T+k, -1 on timeout.
    task automatic run_pixel(input int idx, input bit spam, output int latency);
        int c0;
        @(negedge clk);
        start = 1'b1; px_idx = 12'(idx);
        @(posedge clk); #1;
        c0 = cyc;
        latency = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                latency = cyc - c0 + 1;
                start = 1'b0;
                break;
            end
            start  = spam ? ~start : 1'b0;
            px_idx = spam ? 12'd5 : px_idx;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    function automatic int count_touched();
        int n = 0;
        for (int i = 0; i < 4096; i++) if (touched[i]) n++;
        return n;
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; px_idx = 12'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", int'({busy, done, sram_rden, sram_wren, sram_addr, sram_wdata, err_q}), 0);
        rst_n = 1'b1;

        // 1: top-left pixel, SW off-image
        poke(0, 200); poke(1, 100); poke(64, 100); poke(65, 100); poke(63, 33);
        clear_mon();
        run_pixel(0, 1'b0, lat);
        check_eq("t1_lat", lat, 13);
        check_eq("t1_old", int'(mem[0]), 255);
        check_eq("t1_err", int'(err_q), -55);
        check_eq("t1_e", int'(mem[1]), rv(75, 76));
        check_eq("t1_s", int'(mem[64]), rv(82, 83));
        check_eq("t1_se", int'(mem[65]), rv(96, 97));
        check_eq("t1_sw_untouched", int'(touched[63]), 0);
        check_eq("t1_sw_data", int'(mem[63]), 33);

        // 2: positive error with saturation on E
        poke(10, 100); poke(11, 250); poke(73, 0); poke(74, 0); poke(75, 0);
        clear_mon();
        run_pixel(10, 1'b0, lat);
        check_eq("t2_lat", lat, 16);
        check_eq("t2_old", int'(mem[10]), 0);
        check_eq("t2_err", int'(err_q), 100);
        check_eq("t2_e_sat", int'(mem[11]), 255);
        check_eq("t2_sw", int'(mem[73]), rv(18, 19));
        check_eq("t2_s", int'(mem[74]), 31);
        check_eq("t2_se", int'(mem[75]), 6);

        // 3: right edge, E and SE skipped
        poke(63, 50); poke(126, 10); poke(127, 250);
        clear_mon();
        run_pixel(63, 1'b0, lat);
        check_eq("t3_lat", lat, 10);
        check_eq("t3_old", int'(mem[63]), 0);
        check_eq("t3_sw", int'(mem[126]), 19);
        check_eq("t3_s", int'(mem[127]), 255);
        check_eq("t3_no64", int'(touched[64]), 0);
        check_eq("t3_no128", int'(touched[128]), 0);

        // 4: last pixel, no neighbours
        poke(4095, 128);
        clear_mon();
        run_pixel(4095, 1'b0, lat);
        check_eq("t4_lat", lat, 4);
        check_eq("t4_old", int'(mem[4095]), 255);
        check_eq("t4_err", int'(err_q), -127);
        check_eq("t4_touch", count_touched(), 1);

        // 5: start toggled throughout the operation must be ignored
        poke(130, 127); poke(131, 100); poke(193, 100); poke(194, 100); poke(195, 100); poke(5, 77);
        clear_mon();
        run_pixel(130, 1'b1, lat);
        check_eq("t5_lat", lat, 16);
        check_eq("t5_done_cnt", done_cnt, 1);
        check_eq("t5_old", int'(mem[130]), 0);
        check_eq("t5_e", int'(mem[131]), rv(155, 156));
        check_eq("t5_sw", int'(mem[193]), rv(123, 124));
        check_eq("t5_s", int'(mem[194]), rv(139, 140));
        check_eq("t5_se", int'(mem[195]), rv(107, 108));
        check_eq("t5_no_idx5", int'(touched[5]), 0);
        check_eq("t5_touch", count_touched(), 5);
        check_eq("rden_wren_exclusive", excl_err, 0);

        // 6: reset while waiting on the E neighbour read
        poke(200, 200); poke(201, 100);
        @(negedge clk); start = 1'b1; px_idx = 12'd200;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t6_wait_n", int'({busy, sram_rden, sram_wren, sram_addr}), int'({3'b100, 12'd201}));
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t6_reset_outputs", int'({busy, done, sram_rden, sram_wren, sram_addr, sram_wdata, err_q}), 0);
        rst_n = 1'b1;
        check_eq("t6_partial_kept", int'(mem[200]), 255);
        check_eq("t6_e_unchanged", int'(mem[201]), 100);
        poke(4094, 10);
        clear_mon();
        run_pixel(4094, 1'b0, lat);
        check_eq("t6_restart_lat", lat, 7);
        check_eq("t6_restart_err", int'(err_q), 10);
        check_eq("t6_restart_old", int'(mem[4094]), 0);
        check_eq("t6_restart_e", int'(mem[4095]), 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
